mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; a responder on the CPU data port (same w_en/d_addr/d_in/d_size

---
 rtl/mmio_uart_tx.sv | 172 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores queue bytes in a FIFO that a
// serialiser drains onto tx; loads return status with one-cycle registered latency.
module mmio_uart_tx #(
  parameter int DEPTH   = 8,
  parameter int DIV_RST = 868,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        w_en,
  input  logic [3:0]  d_addr,
  input  logic [31:0] d_in,
  input  logic [1:0]  d_size,
  output logic [31:0] d_out,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_dOut;
  state_t           r_state;
  logic [DIV_W-1:0] r_bitLen;
  logic [DIV_W-1:0] r_baud;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic             w_load;
  logic             w_store;
  logic [1:0]       w_reg;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_push;
  logic             w_pop;
  logic             w_bitEnd;
  logic [3:0]       w_count4;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_load   = sel & ~w_en;
  assign w_store  = sel & w_en;
  assign w_reg    = d_addr[3:2];
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_busy   = (r_state != IDLE);
  assign w_push   = w_store && (w_reg == 2'd0) && !w_full;
  assign w_pop    = (r_state == IDLE) && !w_empty;
  assign w_bitEnd = (r_baud == r_bitLen - 1'b1);
  // Access width never matters, so size and byte-lane bits are deliberately dropped.
  assign w_unused = ^{d_size, d_addr[1:0], d_in};

  always_comb begin
    w_count4 = 4'(r_count);
    if (32'(r_count) > 15) w_count4 = 4'hF;
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      2'd1:    w_rdata = {24'b0, w_count4, r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_rdata = 32'(r_div);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= d_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_store && (w_reg == 2'd0) && w_full)       r_ovf <= 1'b1;
      else if (w_store && (w_reg == 2'd1) && d_in[3]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= DIV_W'(DIV_RST);
      r_dOut <= '0;
    end else begin
      if (w_store && (w_reg == 2'd2)) r_div <= d_in[DIV_W-1:0];
      if (w_load) r_dOut <= w_rdata;
    end
  end

  // Bit length is captured at pop so divisor writes only affect later frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_baud   <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_bitLen <= DIV_W'(1);
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state  <= START;
            r_tx     <= 1'b0;
            r_shift  <= r_mem[r_rdPtr];
            r_bitLen <= (r_div == '0) ? DIV_W'(1) : r_div;
            r_baud   <= '0;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_state  <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_baud <= '0;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            r_baud  <= '0;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign d_out = r_dOut;
  assign tx    = r_tx;
  assign irq   = w_empty & ~w_busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: bus accesses, frame timing, FIFO overflow and
// mid-frame reset, with every tx cycle of each frame compared against a bit-level model.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        w_en;
  logic [3:0]  d_addr;
  logic [31:0] d_in;
  logic [1:0]  d_size;
  logic [31:0] d_out;
  logic        tx;
  logic        irq;

  int nAsserts = 0;
  int nFails   = 0;

  mmio_uart_tx dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .w_en   (w_en),
    .d_addr (d_addr),
    .d_in   (d_in),
    .d_size (d_size),
    .d_out  (d_out),
    .tx     (tx),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; the access is sampled at the next rising edge.
  task automatic applyStimulus(input logic s, input logic we, input logic [3:0] a,
                               input logic [31:0] d, input logic [1:0] sz);
    sel = s; w_en = we; d_addr = a; d_in = d; d_size = sz;
    tick();
    sel = 1'b0; w_en = 1'b0; d_addr = '0; d_in = '0; d_size = '0;
  endtask

  task automatic waitFall(input int limit, output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < limit) begin
      tick();
      waited++;
    end
  endtask

  // Frame cycle c (0 = first start-bit cycle) carries bit c/p: start, 8 data LSB first, stop.
  function automatic logic expBit(input logic [7:0] data, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return data[idx-1];
  endfunction

  task automatic checkBits(input string tag, input logic [7:0] data, input int p,
                           input int from, input int to);
    for (int c = from; c <= to; c++) begin
      tick();
      checkOutput($sformatf("%s c%0d", tag, c), 32'({tx, irq}), 32'({expBit(data, c / p), 1'b0}));
    end
  endtask

  initial begin
    int w;
    logic [7:0] bytes3 [10];

    reset = 1'b1; sel = 1'b0; w_en = 1'b0; d_addr = '0; d_in = '0; d_size = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and register reads
    $display("[TB] test 1: reset state");
    checkOutput("t1 tx", 32'(tx), 32'd1);
    checkOutput("t1 irq", 32'(irq), 32'd1);
    checkOutput("t1 dout", d_out, 32'h0);
    applyStimulus(1, 0, 4'h4, 0, 2'b10);
    checkOutput("t1 status", d_out, 32'h0000_0002);
    applyStimulus(1, 0, 4'h8, 0, 2'b10);
    checkOutput("t1 divisor", d_out, 32'd868);
    applyStimulus(1, 0, 4'h0, 0, 2'b00);
    checkOutput("t1 txdata rd", d_out, 32'h0);
    applyStimulus(1, 1, 4'h8, 32'd77, 2'b10);
    applyStimulus(1, 0, 4'hC, 0, 2'b10);
    checkOutput("t1 reserved rd", d_out, 32'h0);
    applyStimulus(1, 0, 4'h8, 0, 2'b10);
    applyStimulus(0, 1, 4'h0, 32'hAB, 2'b00);
    applyStimulus(0, 1, 4'h8, 32'd5, 2'b10);
    checkOutput("t1 dout hold", d_out, 32'd77);
    waitFall(20, w);
    checkOutput("t1 unsel quiet", 32'(w), 32'd20);
    checkOutput("t1 unsel irq", 32'(irq), 32'd1);
    applyStimulus(1, 0, 4'h8, 0, 2'b10);
    checkOutput("t1 unsel div", d_out, 32'd77);

    $display("[TB] test 2: 0x55 at div 4");
    applyStimulus(1, 1, 4'h8, 32'hFFFF_0004, 2'b01);
    applyStimulus(1, 1, 4'h0, 32'h1234_5655, 2'b00);
    checkOutput("t2 irq after store", 32'(irq), 32'd0);
    waitFall(10, w);
    checkOutput("t2 latency", 32'(w), 32'd1);
    checkBits("t2 frame", 8'h55, 4, 1, 39);
    tick();
    checkOutput("t2 idle", 32'({tx, irq}), 32'b11);

    $display("[TB] test 3: overflow at div 2");
    for (int i = 0; i < 10; i++) bytes3[i] = 8'(8'h3B * i + 8'h61);
    applyStimulus(1, 1, 4'h8, 32'd2, 2'b10);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 4'h0, 32'(bytes3[i]), 2'b00);
    applyStimulus(1, 0, 4'h4, 0, 2'b10);
    checkOutput("t3 status full", d_out, 32'h0000_008D);
    applyStimulus(1, 1, 4'h4, 32'h8, 2'b10);
    applyStimulus(1, 0, 4'h4, 0, 2'b10);
    checkOutput("t3 status cleared", d_out, 32'h0000_0085);
    checkBits("t3 b0", bytes3[0], 2, 12, 19);
    for (int i = 1; i < 9; i++) begin
      waitFall(10, w);
      checkOutput($sformatf("t3 gap%0d", i), 32'(w), 32'd2);
      checkBits($sformatf("t3 b%0d", i), bytes3[i], 2, 1, 19);
    end
    waitFall(40, w);
    checkOutput("t3 dropped quiet", 32'(w), 32'd40);
    checkOutput("t3 end idle", 32'({tx, irq}), 32'b11);
    applyStimulus(1, 0, 4'h4, 0, 2'b10);
    checkOutput("t3 status end", d_out, 32'h0000_0002);

    $display("[TB] test 4: divisor change mid-frame");
    applyStimulus(1, 1, 4'h8, 32'd4, 2'b10);
    applyStimulus(1, 1, 4'h0, 32'hA5, 2'b00);
    waitFall(10, w);
    checkOutput("t4 latency", 32'(w), 32'd1);
    checkBits("t4 a5", 8'hA5, 4, 1, 16);
    applyStimulus(1, 1, 4'h8, 32'd8, 2'b01);
    applyStimulus(1, 1, 4'h0, 32'h3C, 2'b00);
    checkBits("t4 a5", 8'hA5, 4, 19, 39);
    waitFall(10, w);
    checkOutput("t4 gap", 32'(w), 32'd2);
    checkBits("t4 3c", 8'h3C, 8, 1, 79);
    tick();
    checkOutput("t4 idle", 32'({tx, irq}), 32'b11);

    $display("[TB] test 5: div 0");
    applyStimulus(1, 1, 4'h8, 32'd0, 2'b10);
    applyStimulus(1, 1, 4'h0, 32'hFF, 2'b00);
    waitFall(10, w);
    checkOutput("t5 latency", 32'(w), 32'd1);
    checkBits("t5 ff", 8'hFF, 1, 1, 9);
    tick();
    checkOutput("t5 idle", 32'({tx, irq}), 32'b11);

    $display("[TB] test 6: reset mid-frame");
    applyStimulus(1, 1, 4'h8, 32'd4, 2'b10);
    applyStimulus(1, 1, 4'h0, 32'h5A, 2'b00);
    applyStimulus(1, 1, 4'h0, 32'hC3, 2'b00);
    applyStimulus(1, 1, 4'h0, 32'h0F, 2'b00);
    checkOutput("t6 start", 32'(tx), 32'd0);
    checkBits("t6 5a", 8'h5A, 4, 2, 25);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6 after reset", 32'({tx, irq}), 32'b11);
    applyStimulus(1, 0, 4'h4, 0, 2'b10);
    checkOutput("t6 status", d_out, 32'h0000_0002);
    applyStimulus(1, 0, 4'h8, 0, 2'b10);
    checkOutput("t6 divisor", d_out, 32'd868);
    waitFall(60, w);
    checkOutput("t6 quiet", 32'(w), 32'd60);
    checkOutput("t6 quiet tx", 32'(tx), 32'd1);
    applyStimulus(1, 1, 4'h8, 32'd3, 2'b10);
    applyStimulus(1, 1, 4'h0, 32'h96, 2'b00);
    waitFall(10, w);
    checkOutput("t6 latency", 32'(w), 32'd1);
    checkBits("t6 96", 8'h96, 3, 1, 29);
    tick();
    checkOutput("t6 idle", 32'({tx, irq}), 32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
